// File: rtl/insn_decoder_dbg.sv
// DekatronPC instruction decoder/sequencer with multi-step, IP breakpoint,
// console-handshake timeout, retired-instruction counter and halt reason.
module insn_decoder_dbg #(
    parameter int INSN_WIDTH  = 4,
    parameter int IP_WIDTH    = 16,
    parameter int STEP_WIDTH  = 8,
    parameter int IRET_WIDTH  = 32,
    parameter int CIO_TIMEOUT = 65535,
    parameter bit RESET_MODE  = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Halt,
    input  logic                  Step,
    input  logic                  Run,
    input  logic [STEP_WIDTH-1:0] StepN,
    input  logic                  BpEn,
    input  logic [IP_WIDTH-1:0]   BpAddr,
    input  logic [IP_WIDTH-1:0]   IpAddr,
    input  logic [INSN_WIDTH-1:0] Insn,
    input  logic                  IpLineReady,
    input  logic                  ApLineReady,
    input  logic                  DataZero,
    input  logic                  ApZero,
    input  logic                  CioAcq,
    input  logic                  EchoMode,
    output logic                  LoopValZero,
    output logic                  ApRequest,
    output logic                  ApLineCin,
    output logic                  ApLineDec,
    output logic                  ApLineZero,
    output logic                  IpRequest,
    output logic                  DataRequest,
    output logic                  CinReq,
    output logic                  Cout,
    output logic [2:0]            state,
    output logic                  IsHalted,
    output logic [2:0]            HaltReason,
    output logic                  CioErr,
    output logic [IRET_WIDTH-1:0] IRET
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd1,
        S_FETCH   = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4,
        S_CIN     = 3'd5,
        S_COUT    = 3'd6,
        S_CIO_ACQ = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            reason_q, reason_d;
    logic                  cioerr_q, cioerr_d;
    logic [IRET_WIDTH-1:0] iret_q, iret_d;
    logic                  mode_q, mode_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic                  bpskip_q, bpskip_d;
    logic                  echo_q, echo_d;
    logic [31:0]           timer_q, timer_d;
    logic                  apreq_q, apreq_d;
    logic                  apcin_q, apcin_d;
    logic                  apdec_q, apdec_d;
    logic                  apzero_q, apzero_d;
    logic                  ipreq_q, ipreq_d;
    logic                  datareq_q, datareq_d;
    logic                  cinreq_q, cinreq_d;
    logic                  cout_q, cout_d;

    logic       insn_hi_zero;
    logic [3:0] op;
    logic       loop_zero;
    logic       bp_hit;
    logic       cio_state;
    logic       tmo;

    // Opcodes with any bit set above the low nibble decode as NOP.
    if (INSN_WIDTH > 4) begin : g_hi
        assign insn_hi_zero = (Insn[INSN_WIDTH-1:4] == '0);
    end else begin : g_nohi
        assign insn_hi_zero = 1'b1;
    end

    assign op        = Insn[3:0];
    assign loop_zero = mode_q ? DataZero : ApZero;
    assign bp_hit    = BpEn && (IpAddr == BpAddr) && !bpskip_q;
    assign cio_state = (state_q == S_CIN) || (state_q == S_COUT)
                    || (state_q == S_CIO_ACQ);
    assign tmo       = (CIO_TIMEOUT != 0) && cio_state
                    && (timer_q + 32'd1 == 32'(CIO_TIMEOUT));

    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        cioerr_d  = cioerr_q;
        iret_d    = iret_q;
        mode_d    = mode_q;
        step_d    = step_q;
        bpskip_d  = bpskip_q;
        echo_d    = echo_q;
        timer_d   = '0;
        apreq_d   = apreq_q;
        apcin_d   = apcin_q;
        apdec_d   = apdec_q;
        apzero_d  = apzero_q;
        ipreq_d   = ipreq_q;
        datareq_d = datareq_q;
        cinreq_d  = cinreq_q;
        cout_d    = cout_q;

        case (state_q)
            S_HALT: begin
                if (Step) begin
                    state_d  = S_IDLE;
                    step_d   = (StepN == '0) ? STEP_WIDTH'(1) : StepN;
                    bpskip_d = 1'b1;
                    cioerr_d = 1'b0;
                end else if (Run) begin
                    state_d  = S_IDLE;
                    step_d   = '0;
                    bpskip_d = 1'b1;
                    cioerr_d = 1'b0;
                end
            end
            S_IDLE: begin
                if (Halt) begin
                    state_d  = S_HALT;
                    reason_d = 3'd2;
                end else begin
                    ipreq_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ipreq_d = 1'b0;
                cout_d  = 1'b0;
                if (IpLineReady) begin
                    bpskip_d = 1'b0;
                    if (bp_hit) begin
                        state_d  = S_HALT;
                        reason_d = 3'd4;
                    end else if (!insn_hi_zero) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_EXEC;
                        case (op)
                            4'h0: state_d = S_IDLE;
                            4'h1: begin
                                state_d  = S_HALT;
                                reason_d = 3'd1;
                            end
                            4'h6: begin
                                if (loop_zero) begin
                                    ipreq_d = 1'b1;
                                    state_d = S_FETCH;
                                end
                            end
                            4'h7: begin
                                if (!loop_zero) begin
                                    ipreq_d = 1'b1;
                                    state_d = S_FETCH;
                                end
                            end
                            4'hA: begin
                                datareq_d = 1'b1;
                                apzero_d  = 1'b1;
                            end
                            4'hB: begin
                                if (!mode_q) begin
                                    apreq_d  = 1'b1;
                                    apzero_d = 1'b1;
                                end
                            end
                            4'h2, 4'h3: begin
                                if (mode_q) begin
                                    datareq_d = 1'b1;
                                    apdec_d   = op[0];
                                end
                            end
                            4'h4, 4'h5: begin
                                if (mode_q) begin
                                    apreq_d = 1'b1;
                                    apdec_d = op[0];
                                end
                            end
                            4'h8: begin
                                if (mode_q) begin
                                    cout_d  = 1'b1;
                                    state_d = S_COUT;
                                end
                            end
                            4'h9: begin
                                if (mode_q) begin
                                    cinreq_d = 1'b1;
                                    state_d  = S_CIN;
                                end
                            end
                            4'hE: mode_d = 1'b0;
                            4'hF: mode_d = 1'b1;
                            default: state_d = S_EXEC;
                        endcase
                    end
                end
            end
            S_EXEC: begin
                datareq_d = 1'b0;
                apreq_d   = 1'b0;
                apzero_d  = 1'b0;
                apcin_d   = 1'b0;
                if (ApLineReady) begin
                    iret_d = iret_q + IRET_WIDTH'(1);
                    if (step_q != '0) begin
                        step_d = step_q - STEP_WIDTH'(1);
                    end
                    if (Halt) begin
                        state_d  = S_HALT;
                        reason_d = 3'd2;
                    end else if (step_q == STEP_WIDTH'(1)) begin
                        state_d  = S_HALT;
                        reason_d = 3'd3;
                    end else begin
                        ipreq_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_CIN: begin
                if (tmo) begin
                    state_d = S_HALT;
                end else if (CioAcq) begin
                    datareq_d = 1'b1;
                    apcin_d   = 1'b1;
                    cinreq_d  = 1'b0;
                    echo_d    = EchoMode;
                    state_d   = S_CIO_ACQ;
                end
            end
            S_COUT: begin
                if (tmo) begin
                    state_d = S_HALT;
                end else if (CioAcq) begin
                    cout_d  = 1'b0;
                    state_d = S_CIO_ACQ;
                end
            end
            S_CIO_ACQ: begin
                datareq_d = 1'b0;
                apcin_d   = 1'b0;
                if (tmo) begin
                    state_d = S_HALT;
                end else if (ApLineReady && !CioAcq) begin
                    if (echo_q) begin
                        cout_d  = 1'b1;
                        echo_d  = 1'b0;
                        state_d = S_COUT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stuck console handshake abandons the request and halts.
        if (tmo) begin
            cinreq_d = 1'b0;
            cout_d   = 1'b0;
            cioerr_d = 1'b1;
            reason_d = 3'd5;
        end

        if (cio_state && (state_d == state_q)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_HALT;
            reason_q  <= '0;
            cioerr_q  <= 1'b0;
            iret_q    <= '0;
            mode_q    <= RESET_MODE;
            step_q    <= '0;
            bpskip_q  <= 1'b0;
            echo_q    <= 1'b0;
            timer_q   <= '0;
            apreq_q   <= 1'b0;
            apcin_q   <= 1'b0;
            apdec_q   <= 1'b0;
            apzero_q  <= 1'b0;
            ipreq_q   <= 1'b0;
            datareq_q <= 1'b0;
            cinreq_q  <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            reason_q  <= reason_d;
            cioerr_q  <= cioerr_d;
            iret_q    <= iret_d;
            mode_q    <= mode_d;
            step_q    <= step_d;
            bpskip_q  <= bpskip_d;
            echo_q    <= echo_d;
            timer_q   <= timer_d;
            apreq_q   <= apreq_d;
            apcin_q   <= apcin_d;
            apdec_q   <= apdec_d;
            apzero_q  <= apzero_d;
            ipreq_q   <= ipreq_d;
            datareq_q <= datareq_d;
            cinreq_q  <= cinreq_d;
            cout_q    <= cout_d;
        end
    end

    assign LoopValZero = loop_zero;
    assign ApRequest   = apreq_q;
    assign ApLineCin   = apcin_q;
    assign ApLineDec   = apdec_q;
    assign ApLineZero  = apzero_q;
    assign IpRequest   = ipreq_q;
    assign DataRequest = datareq_q;
    assign CinReq      = cinreq_q;
    assign Cout        = cout_q;
    assign state       = state_q;
    assign IsHalted    = (state_q == S_HALT);
    assign HaltReason  = reason_q;
    assign CioErr      = cioerr_q;
    assign IRET        = iret_q;

endmodule

// File: tb/tb_insn_decoder_dbg.sv
// Bench for insn_decoder_dbg: IP/AP/console responders plus an ISA-level
// program model that predicts retires, halt cause and line activity.
`timescale 1ns/1ps
module tb_insn_decoder_dbg;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Halt = 1'b0;
    logic        Step = 1'b0;
    logic        Run = 1'b0;
    logic [7:0]  StepN = '0;
    logic        BpEn = 1'b0;
    logic [15:0] BpAddr = '0;
    logic [15:0] IpAddr;
    logic [3:0]  Insn;
    logic        IpLineReady;
    logic        ApLineReady;
    logic        DataZero = 1'b1;
    logic        ApZero = 1'b0;
    logic        CioAcq;
    logic        EchoMode = 1'b0;
    logic        LoopValZero;
    logic        ApRequest, ApLineCin, ApLineDec, ApLineZero;
    logic        IpRequest, DataRequest, CinReq, Cout;
    logic [2:0]  state;
    logic        IsHalted;
    logic [2:0]  HaltReason;
    logic        CioErr;
    logic [31:0] IRET;

    always #5 Clk = ~Clk;

    insn_decoder_dbg #(.CIO_TIMEOUT(10)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Halt(Halt), .Step(Step), .Run(Run),
        .StepN(StepN), .BpEn(BpEn), .BpAddr(BpAddr), .IpAddr(IpAddr),
        .Insn(Insn), .IpLineReady(IpLineReady), .ApLineReady(ApLineReady),
        .DataZero(DataZero), .ApZero(ApZero), .CioAcq(CioAcq),
        .EchoMode(EchoMode), .LoopValZero(LoopValZero),
        .ApRequest(ApRequest), .ApLineCin(ApLineCin), .ApLineDec(ApLineDec),
        .ApLineZero(ApLineZero), .IpRequest(IpRequest),
        .DataRequest(DataRequest), .CinReq(CinReq), .Cout(Cout),
        .state(state), .IsHalted(IsHalted), .HaltReason(HaltReason),
        .CioErr(CioErr), .IRET(IRET)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] mem [0:63];
    int  pc = 0;
    int  ip_wait = -1;
    int  ap_busy = 0;
    int  aplog[$];
    bit  con_en = 1'b1;
    int  con_wait = 0;
    int  n_cout = 0, n_cin = 0, n_skip = 0;

    // model state / expectations
    bit  m_mode = 1'b1;
    int  exp_ops[$];
    int  exp_ret, exp_reason, exp_cout, exp_cin;

    // IP line: fetch mem[pc] a random 0..2 cycles after IpRequest.
    initial begin
        IpLineReady = 1'b0;
        IpAddr = '0;
        Insn = '0;
        forever begin
            @(posedge Clk); #1;
            IpLineReady = 1'b0;
            if (ip_wait > 0) ip_wait--;
            else if (ip_wait < 0 && IpRequest)
                ip_wait = $urandom_range(0, 2);
            if (ip_wait == 0) begin
                IpAddr = 16'(pc);
                Insn = mem[pc % 64];
                IpLineReady = 1'b1;
                pc++;
                ip_wait = -1;
            end
        end
    end

    // AP line: busy (ready low) for 1..3 cycles after each request.
    initial begin
        ApLineReady = 1'b1;
        forever begin
            @(posedge Clk); #1;
            if (ap_busy > 0) begin
                ap_busy--;
                if (ap_busy == 0) ApLineReady = 1'b1;
            end else if (DataRequest || ApRequest) begin
                ApLineReady = 1'b0;
                ap_busy = $urandom_range(1, 3);
                if (ApLineCin) aplog.push_back(8);
                else if (ApLineZero) aplog.push_back(ApRequest ? 6 : 4);
                else aplog.push_back((ApRequest ? 2 : 0) + int'(ApLineDec));
            end
        end
    end

    // Console handshake plus edge counters.
    initial begin
        logic cout_p, cin_p;
        logic [2:0] st_p;
        cout_p = 1'b0;
        cin_p = 1'b0;
        st_p = 3'd4;
        CioAcq = 1'b0;
        forever begin
            @(posedge Clk); #1;
            if (Cout && !cout_p) n_cout++;
            if (CinReq && !cin_p) n_cin++;
            if (IpRequest && state == 3'd2 && st_p == 3'd2) n_skip++;
            cout_p = Cout;
            cin_p = CinReq;
            st_p = state;
            if (!con_en) begin
                CioAcq = 1'b0;
                con_wait = 0;
            end else if (CioAcq) begin
                if (!(Cout || CinReq)) CioAcq = 1'b0;
            end else if (Cout || CinReq) begin
                if (con_wait == 0) con_wait = $urandom_range(1, 3);
                con_wait--;
                if (con_wait == 0) CioAcq = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input logic [3:0] v);
        for (int i = 0; i < 64; i++) mem[i] = v;
    endtask

    task automatic pulse_run();
        Run = 1'b1;
        tick();
        Run = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int k = 0; k < 3000; k++) begin
            if (IsHalted) break;
            tick();
        end
        chk({tag, "_halted"}, IsHalted, 1'b1);
    endtask

    // ISA-level prediction of one program run from 'start' until HALT.
    task automatic model_prog(input int start);
        int p;
        logic [3:0] o;
        bit lz;
        exp_ops.delete();
        exp_ret = 0;
        exp_reason = 0;
        exp_cout = 0;
        exp_cin = 0;
        p = start;
        for (int k = 0; k < 64; k++) begin
            o = mem[p % 64];
            p++;
            lz = m_mode ? DataZero : ApZero;
            if (o == 4'h1) begin
                exp_reason = 1;
                break;
            end
            if (o == 4'h0) continue;
            if ((o == 4'h6 && lz) || (o == 4'h7 && !lz)) continue;
            exp_ret++;
            case (o)
                4'hA: exp_ops.push_back(4);
                4'hB: if (!m_mode) exp_ops.push_back(6);
                4'h2: if (m_mode) exp_ops.push_back(0);
                4'h3: if (m_mode) exp_ops.push_back(1);
                4'h4: if (m_mode) exp_ops.push_back(2);
                4'h5: if (m_mode) exp_ops.push_back(3);
                4'h8: if (m_mode) exp_cout++;
                4'h9: if (m_mode) begin
                    exp_cin++;
                    exp_ops.push_back(8);
                    exp_cout += int'(EchoMode);
                end
                4'hE: m_mode = 1'b0;
                4'hF: m_mode = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic run_prog(input string tag);
        logic [31:0] iret0;
        int n;
        iret0 = IRET;
        aplog.delete();
        n_cout = 0;
        n_cin = 0;
        pc = 0;
        model_prog(0);
        pulse_run();
        wait_halt(tag);
        chk({tag, "_retired"}, IRET - iret0, 32'(exp_ret));
        chk({tag, "_reason"}, HaltReason, 3'(exp_reason));
        chk({tag, "_apops"}, aplog.size(), exp_ops.size());
        n = (aplog.size() < exp_ops.size()) ? aplog.size() : exp_ops.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_apop"}, aplog[i], exp_ops[i]);
        chk({tag, "_cout"}, n_cout, exp_cout);
        chk({tag, "_cin"}, n_cin, exp_cin);
        chk({tag, "_loopval"}, LoopValZero, m_mode ? DataZero : ApZero);
    endtask

    task automatic step_test(input int sn, input bit with_run,
                             input string tag);
        logic [31:0] iret0;
        fill_mem(4'h2);
        pc = 0;
        iret0 = IRET;
        StepN = 8'(sn);
        Step = 1'b1;
        Run = with_run;
        tick();
        Step = 1'b0;
        Run = 1'b0;
        wait_halt(tag);
        chk({tag, "_retired"}, IRET - iret0, 32'((sn == 0) ? 1 : sn));
        chk({tag, "_reason"}, HaltReason, 3'd3);
    endtask

    initial begin
        logic [31:0] iret0;
        int cyc;
        int len;
        int o;

        fill_mem(4'h1);
        repeat (3) tick();
        chk("rst_state", state, 3'd4);
        chk("rst_halted", IsHalted, 1'b1);
        chk("rst_reason", HaltReason, 3'd0);
        chk("rst_cioerr", CioErr, 1'b0);
        chk("rst_iret", IRET, 32'd0);
        chk("rst_lines", {ApRequest, ApLineCin, ApLineDec, ApLineZero,
                          IpRequest, DataRequest, CinReq, Cout}, 8'h00);
        chk("rst_bfmode", LoopValZero, 1'b1);
        Rst_n = 1'b1;
        tick();
        chk("post_rst_state", state, 3'd4);

        // small BF program
        mem[0] = 4'h2; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h1;
        run_prog("bf_prog");

        step_test(3, 1'b0, "step3");
        step_test(0, 1'b0, "step0");
        step_test(2, 1'b1, "step_over_run");

        // Halt held at IDLE halts before any fetch
        iret0 = IRET;
        Halt = 1'b1;
        pulse_run();
        wait_halt("halt_idle");
        chk("halt_idle_reason", HaltReason, 3'd2);
        chk("halt_idle_retired", IRET - iret0, 32'd0);
        Halt = 1'b0;

        // Halt raised while running is taken at EXEC
        fill_mem(4'h2);
        pc = 0;
        iret0 = IRET;
        pulse_run();
        repeat (15) tick();
        Halt = 1'b1;
        wait_halt("halt_run");
        chk("halt_run_reason", HaltReason, 3'd2);
        chk("halt_run_progress", IRET != iret0, 1'b1);
        Halt = 1'b0;

        // breakpoint at 5, then resume through it
        fill_mem(4'h2);
        mem[7] = 4'h1;
        pc = 0;
        BpEn = 1'b1;
        BpAddr = 16'd5;
        iret0 = IRET;
        pulse_run();
        wait_halt("bp");
        chk("bp_reason", HaltReason, 3'd4);
        chk("bp_retired", IRET - iret0, 32'd5);
        chk("bp_addr", IpAddr, 16'd5);
        pc = 5;
        iret0 = IRET;
        pulse_run();
        wait_halt("bp_resume");
        chk("bp_resume_reason", HaltReason, 3'd1);
        chk("bp_resume_retired", IRET - iret0, 32'd2);
        BpEn = 1'b0;

        // console timeout on CIN
        fill_mem(4'h1);
        mem[0] = 4'h9;
        pc = 0;
        con_en = 1'b0;
        iret0 = IRET;
        pulse_run();
        for (int k = 0; k < 100; k++) begin
            if (state == 3'd5) break;
            tick();
        end
        chk("tmo_cin_entered", state, 3'd5);
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            cyc++;
            if (state != 3'd5) break;
        end
        chk("tmo_cycles", cyc, 10);
        chk("tmo_state", state, 3'd4);
        chk("tmo_cinreq", CinReq, 1'b0);
        chk("tmo_cioerr", CioErr, 1'b1);
        chk("tmo_reason", HaltReason, 3'd5);
        chk("tmo_retired", IRET - iret0, 32'd0);
        con_en = 1'b1;
        pulse_run();
        chk("tmo_cleared", CioErr, 1'b0);
        wait_halt("tmo_after");
        chk("tmo_after_reason", HaltReason, 3'd1);

        // CIN with echo
        fill_mem(4'h1);
        mem[0] = 4'h9;
        EchoMode = 1'b1;
        run_prog("echo");
        EchoMode = 1'b0;

        // DEBUG mode, loop skip and zeroing AP request
        fill_mem(4'h1);
        mem[0] = 4'hE; mem[1] = 4'h6; mem[2] = 4'h2; mem[3] = 4'hB;
        ApZero = 1'b1;
        DataZero = 1'b0;
        n_skip = 0;
        run_prog("dbg_loop");
        chk("dbg_loop_skip", n_skip, 1);

        // randomized programs
        for (int r = 0; r < 10; r++) begin
            fill_mem(4'h1);
            len = $urandom_range(3, 12);
            for (int i = 0; i < len; i++) begin
                o = $urandom_range(0, 14);
                if (o >= 1) o++;
                mem[i] = 4'(o);
            end
            DataZero = 1'($urandom_range(0, 1));
            ApZero = 1'($urandom_range(0, 1));
            EchoMode = 1'($urandom_range(0, 1));
            run_prog("rand");
        end

        // reset while Cout is pending
        fill_mem(4'h1);
        mem[0] = 4'hF;
        mem[1] = 4'h8;
        pc = 0;
        con_en = 1'b0;
        pulse_run();
        for (int k = 0; k < 200; k++) begin
            if (Cout) break;
            tick();
        end
        chk("midrst_cout_seen", Cout, 1'b1);
        Rst_n = 1'b0;
        #1;
        chk("midrst_cout", Cout, 1'b0);
        chk("midrst_state", state, 3'd4);
        chk("midrst_iret", IRET, 32'd0);
        chk("midrst_reason", HaltReason, 3'd0);
        DataZero = 1'b1;
        ApZero = 1'b0;
        #1;
        chk("midrst_bfmode", LoopValZero, 1'b1);
        tick();
        Rst_n = 1'b1;
        con_en = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/insn_decoder_dbg.md
Name: insn_decoder_dbg

Overview:
Parametrised successor of the DekatronPC instruction decoder/sequencer.
- Fetches instructions via the IP line, decodes them in DEBUG or BRAINFUCK ISA mode, and issues AP, data and console (CIO) requests.
- Adds multi-instruction stepping, an IP breakpoint and a console-handshake timeout.
- Adds an always-present retired-instruction counter and a halt-reason code.
- Sits between the IP/AP line controllers, the console block and the switch panel.

Parameters:
- INSN_WIDTH, 4: instruction opcode width; only the low 4 bits are decoded, upper bits must be 0, otherwise the instruction is treated as NOP.
- IP_WIDTH, 16: instruction address width for the breakpoint compare.
- STEP_WIDTH, 8: step-count width.
- IRET_WIDTH, 32: retired-instruction counter width.
- CIO_TIMEOUT, 65535: maximum cycles spent waiting on CioAcq; 0 disables the timeout.
- RESET_MODE, 1: InsnMode after reset (1 = BRAINFUCK, 0 = DEBUG).

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- Halt  in  1  halt request (level).
- Step  in  1  step request (level, sampled in HALT).
- Run  in  1  run request.
- StepN  in  STEP_WIDTH  number of instructions per Step; 0 is treated as 1.
- BpEn  in  1  breakpoint enable.
- BpAddr  in  IP_WIDTH  breakpoint address.
- IpAddr  in  IP_WIDTH  address of the current instruction.
- Insn  in  INSN_WIDTH  fetched instruction.
- IpLineReady  in  1  instruction valid.
- ApLineReady  in  1  AP/data operation complete.
- DataZero  in  1  *AP == 0.
- ApZero  in  1  AP == 0.
- CioAcq  in  1  console acknowledge.
- EchoMode  in  1  echo CIN to COUT.
- LoopValZero  out  1  equals InsnMode ? DataZero : ApZero (combinational).
- ApRequest, ApLineCin, ApLineDec, ApLineZero, IpRequest, DataRequest  out  1 each  line controls.
- CinReq  out  1  console input request.
- Cout  out  1  console output request.
- state  out  3  FSM state.
- IsHalted  out  1  state == HALT.
- HaltReason  out  3  last halt cause.
- CioErr  out  1  sticky console-timeout flag.
- IRET  out  IRET_WIDTH  retired-instruction count.

Behaviour:
- Reset: every output is 0, except state = HALT (3'b100), IsHalted = 1 and HaltReason = 0. Internal state resets to InsnMode = RESET_MODE, StepCnt = 0, BpSkip = 0, Echo = 0 and timer = 0.
- State encoding: IDLE = 1, FETCH = 2, EXEC = 3, HALT = 4, CIN = 5, COUT = 6, CIO_ACQ = 7. Encoding 0 goes to IDLE.
- HALT:
  - Run: go to IDLE, StepCnt = 0.
  - Step (Step has priority over Run): go to IDLE, StepCnt = max(StepN, 1).
  - Either case: BpSkip = 1 and CioErr is cleared.
- IDLE:
  - Halt: go to HALT, reason 2.
  - Otherwise: IpRequest = 1 (one-cycle pulse), go to FETCH.
- FETCH:
  - IpRequest and Cout are cleared.
  - On IpLineReady, breakpoint check first: if BpEn & IpAddr == BpAddr & ~BpSkip, go to HALT with reason 4 and do not execute.
  - BpSkip clears on every IpLineReady.
  - Otherwise decode by Insn[3:0]; "both" means either mode:
    - 0 (both): NOP, go to IDLE.
    - 1 (both): HALT, reason 1.
    - 6 (both): if LoopValZero, pulse IpRequest and stay in FETCH; else go to EXEC.
    - 7 (both): if ~LoopValZero, pulse IpRequest and stay in FETCH; else go to EXEC.
    - A (both): DataRequest = 1, ApLineZero = 1, go to EXEC.
    - B (DEBUG only): ApRequest = 1, ApLineZero = 1, go to EXEC.
    - 2/3 (BF only): DataRequest = 1, ApLineDec = Insn[0], go to EXEC.
    - 4/5 (BF only): ApRequest = 1, ApLineDec = Insn[0], go to EXEC.
    - 8 (BF only): Cout = 1, go to COUT.
    - 9 (BF only): CinReq = 1, go to CIN.
    - E: InsnMode = DEBUG, go to EXEC.
    - F: InsnMode = BF, go to EXEC.
    - Any other opcode: go to EXEC.
- EXEC:
  - DataRequest, ApRequest, ApLineZero and ApLineCin are cleared.
  - On ApLineReady the instruction retires: IRET increments (wrapping).
  - StepCnt decrements if nonzero.
  - Halt goes to HALT, reason 2.
  - Otherwise, if StepCnt decrements to 0, go to HALT, reason 3.
  - Otherwise pulse IpRequest and go to FETCH.
- CIN:
  - On CioAcq: DataRequest = 1, ApLineCin = 1, CinReq = 0, Echo = EchoMode, go to CIO_ACQ.
- COUT:
  - On CioAcq: Cout = 0, go to CIO_ACQ.
- CIO_ACQ:
  - DataRequest and ApLineCin are cleared.
  - On ApLineReady & ~CioAcq: if Echo, set Cout = 1, Echo = 0, go to COUT; else go to EXEC.
- Timeout:
  - The timer counts every cycle spent in CIN/COUT/CIO_ACQ and resets on each state change.
  - If timer == CIO_TIMEOUT (and CIO_TIMEOUT ≠ 0): CinReq = 0, Cout = 0, CioErr = 1, go to HALT, reason 5.
- Halt pending: Halt is not honoured mid-CIO; it is honoured at the next IDLE or EXEC.
- Reset mid-operation: immediate return to reset values, including an in-flight Cout or CinReq.

Test Plan:
- Reset, Run, program {2,2,4,1} in BF mode with ApLineReady 2 cycles after each request → DataRequest pulses twice with ApLineDec = 0, then ApRequest once; HALT with HaltReason = 1 and IRET = 3.
- StepN = 3, Step pulse, stream of 2s → exactly 3 retires, then HALT with reason 3; IRET = 3. Repeat with StepN = 0 → 1 retire.
- BpEn = 1, BpAddr = 5, IpAddr counting 0..9 → HALT with reason 4 at IpAddr 5 and IRET = 5. Run → the instruction at 5 executes, with no re-halt at 5.
- Insn 9 with CioAcq never asserted and CIO_TIMEOUT = 10 → CinReq drops and state = HALT 10 cycles after CIN entry; CioErr = 1, HaltReason = 5. Next Run clears CioErr.
- Insn 9 with EchoMode = 1 and a CioAcq handshake → ApLineCin pulse, then Cout = 1 in COUT; second CioAcq → EXEC and retire with IRET + 1.
- Insn E, then 6 with ApZero = 1 and DataZero = 0 → LoopValZero = 1 and an IpRequest pulse while state stays FETCH; Insn B → ApLineZero with ApRequest.
